adder_digit_sequencer: RTL

Multi-word add controller that sits directly upstream and downstream of the 2-bit ripple adder stage. It accepts WIDTH-bit operands over a valid/ready handshake and feeds them to the external 2-bit adder one digit per cycle, least significant digit first. It chains the adder's carry-out into the next digit's carry-in and reassembles the returned sum digits into a WIDTH-bit result. The result is presented on a valid/ready output handshake.

---
 rtl/adder_digit_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/adder_digit_sequencer.sv
// adder_digit_sequencer
//   Multi-word add controller wrapped around an external 2-bit ripple adder.
//   Operands are accepted on a valid/ready handshake. They are fed to the
//   adder one 2-bit digit per cycle, least significant digit first, with the
//   adder carry-out chained into the next digit. The returned sum digits are
//   reassembled and presented on a valid/ready result handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b, in_cin operands
//   add_a/add_b/add_cin   digit drive to the external 2-bit adder
//   add_sum/add_cout      combinational adder response, same cycle
//   out_valid/out_ready   result handshake; out_sum, out_cout result
//   busy                  operation in flight (RUN or DONE)
//
// WIDTH must be even and >= 2.
module adder_digit_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [1:0]       add_a,
  output logic [1:0]       add_b,
  output logic             add_cin,
  input  logic [1:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_sum_next;

  // A single-digit word has nothing left to shift, so the shifted operands
  // collapse to zero and the new sum digit is the whole result.
  generate
    if (WIDTH == 2) begin : g_one_digit
      assign w_a_next   = '0;
      assign w_b_next   = '0;
      assign w_sum_next = add_sum;
    end else begin : g_multi_digit
      assign w_a_next   = {2'b00, r_a_sh[WIDTH-1:2]};
      assign w_b_next   = {2'b00, r_b_sh[WIDTH-1:2]};
      // Sum digits enter at the top so that after DIGITS shifts digit 0
      // has arrived at bits [1:0].
      assign w_sum_next = {add_sum, r_sum_sh[WIDTH-1:2]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= in_a;
            r_b_sh  <= in_b;
            r_carry <= in_cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh   <= w_a_next;
          r_b_sh   <= w_b_next;
          r_sum_sh <= w_sum_next;
          r_carry  <= add_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_out_sum  <= w_sum_next;
            r_out_cout <= add_cout;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          // in_valid is ignored here; no bypass back into a new operation.
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  wire w_run = (r_state == S_RUN);

  // Held low for the whole reset assertion, not just after the state clears.
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;

  assign add_a   = w_run ? r_a_sh[1:0] : 2'b00;
  assign add_b   = w_run ? r_b_sh[1:0] : 2'b00;
  assign add_cin = w_run ? r_carry     : 1'b0;

endmodule
